// File: rtl/mux_seq_pkg.sv
// Shared definitions for the MUX command sequencer: opcodes, FSM states,
// instruction field positions and MUX device-type codes.
package mux_seq_pkg;

    // Instruction word layout: [31:28] opcode, [27:20] device, [19:0] data
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 28;
    localparam int unsigned DEV_MSB  = 27;
    localparam int unsigned DEV_LSB  = 20;
    localparam int unsigned DATA_MSB = 19;
    localparam int unsigned DATA_LSB = 0;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpOut  = 4'h1,
        OpWait = 4'h2,
        OpSync = 4'h3,
        OpHalt = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StSettle,
        StWaitIdle,
        StDelay
    } state_e;

    // MUX device select: [7:6] type, [5:0] number (6'h3F addresses all)
    localparam logic [1:0] DEV_ADC     = 2'b00;
    localparam logic [1:0] DEV_DAC     = 2'b01;
    localparam logic [1:0] DEV_SW      = 2'b10;
    localparam logic [5:0] DEV_NUM_ALL = 6'h3F;

    function automatic logic [3:0] instr_op(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [7:0] instr_dev(input logic [31:0] word);
        return word[DEV_MSB:DEV_LSB];
    endfunction

    function automatic logic [19:0] instr_data(input logic [31:0] word);
        return word[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/seq_delay_timer.sv
// Microsecond delay timer: TICK_DIV-cycle prescaler driving a 20-bit down-counter.
module seq_delay_timer
    import mux_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [19:0] i_value,
    output logic        o_expired
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // The loading cycle counts as the first prescaler cycle, so a load of n
    // expires n*TICK_DIV cycles after the load cycle itself.
    localparam int unsigned PRE_START = (TICK_DIV > 1) ? 1 : 0;

    logic [PW-1:0] r_prescale;
    logic [19:0]   r_count;
    logic          w_tick;

    assign w_tick    = (r_prescale == PW'(TICK_DIV - 1));
    // Expire in the cycle whose edge takes the count to zero
    assign o_expired = (r_count == 20'd0) || ((r_count == 20'd1) && w_tick);

    // Prescaler and down-counter; loading restarts the prescaler
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prescale <= '0;
            r_count    <= 20'd0;
        end else if (i_load) begin
            r_prescale <= PW'(PRE_START);
            r_count    <= i_value;
        end else if (r_count != 20'd0) begin
            if (w_tick) begin
                r_prescale <= '0;
                r_count    <= r_count - 20'd1;
            end else begin
                r_prescale <= r_prescale + PW'(1);
            end
        end
    end

endmodule

// File: rtl/mux_cmd_sequencer.sv
// MUX command sequencer: fetches instruction words from an FWFT FIFO and
// drives the MUX command port with microsecond delays and idle sync.
module mux_cmd_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100,
    parameter int unsigned SETTLE_CYC   = 4,     // must be >= 1
    parameter int unsigned IDLE_TIMEOUT = 65535  // must be >= 1
) (
    input  logic        fpga_clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_data_i,
    output logic        instr_rd_o,
    output logic        mux_en_o,
    output logic [7:0]  mux_device_o,
    output logic [19:0] mux_data_o,
    input  logic        mux_idle_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] instr_count_o
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);

    state_e        r_state;
    state_e        w_state_next;
    logic [31:0]   r_instr;
    logic          r_mux_en;
    logic [7:0]    r_dev;
    logic [19:0]   r_data;
    logic          r_done;
    logic          r_err;
    logic [15:0]   r_count;
    logic [SW-1:0] r_settle;
    logic [TW-1:0] r_timeout;

    logic          w_instr_rd;
    logic          w_start;
    logic          w_legal;
    logic          w_do_out;
    logic          w_do_wait;
    logic          w_do_halt;
    logic          w_illegal;
    logic          w_timeout;
    logic          w_expired;
    logic          w_timer_load;
    logic [19:0]   w_timer_value;
    logic [3:0]    w_op;
    logic [19:0]   w_op_data;

    assign w_op      = instr_op(r_instr);
    assign w_op_data = instr_data(r_instr);

    // Stop reloads the timer with zero so no stale delay survives an abort
    assign w_timer_load  = w_do_wait || stop_i;
    assign w_timer_value = stop_i ? 20'd0 : w_op_data;

    seq_delay_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_delay_timer (
        .i_clk     (fpga_clk_i),
        .i_rst     (rst_i),
        .i_load    (w_timer_load),
        .i_value   (w_timer_value),
        .o_expired (w_expired)
    );

    // Next-state decode and per-cycle strobes; stop_i overrides everything
    always_comb begin
        w_state_next = r_state;
        w_instr_rd   = 1'b0;
        w_start      = 1'b0;
        w_legal      = 1'b0;
        w_do_out     = 1'b0;
        w_do_wait    = 1'b0;
        w_do_halt    = 1'b0;
        w_illegal    = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_start      = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                if (instr_valid_i) begin
                    w_instr_rd   = 1'b1;
                    w_state_next = StExec;
                end
            end
            StExec: begin
                case (w_op)
                    OpNop: begin
                        w_legal      = 1'b1;
                        w_state_next = StFetch;
                    end
                    OpOut: begin
                        w_legal      = 1'b1;
                        w_do_out     = 1'b1;
                        w_state_next = StSettle;
                    end
                    OpWait: begin
                        w_legal      = 1'b1;
                        w_do_wait    = 1'b1;
                        w_state_next = (w_op_data == 20'd0) ? StFetch : StDelay;
                    end
                    OpSync: begin
                        w_legal      = 1'b1;
                        w_state_next = StWaitIdle;
                    end
                    OpHalt: begin
                        w_legal      = 1'b1;
                        w_do_halt    = 1'b1;
                        w_state_next = StIdle;
                    end
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = StIdle;
                    end
                endcase
            end
            StSettle: begin
                if (r_settle == SW'(SETTLE_CYC - 1)) begin
                    w_state_next = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (mux_idle_i) begin
                    w_state_next = StFetch;
                end else if (r_timeout == TW'(IDLE_TIMEOUT)) begin
                    w_timeout    = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StDelay: begin
                if (w_expired) begin
                    w_state_next = StFetch;
                end
            end
            default: w_state_next = StIdle;
        endcase
        if (stop_i) begin
            w_state_next = StIdle;
            w_instr_rd   = 1'b0;
            w_start      = 1'b0;
            w_legal      = 1'b0;
            w_do_out     = 1'b0;
            w_do_wait    = 1'b0;
            w_do_halt    = 1'b0;
            w_illegal    = 1'b0;
            w_timeout    = 1'b0;
        end
    end

    // State register, instruction register, MUX command and status flags
    always_ff @(posedge fpga_clk_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_instr  <= 32'd0;
            r_mux_en <= 1'b0;
            r_dev    <= 8'd0;
            r_data   <= 20'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= 16'd0;
        end else begin
            r_state  <= w_state_next;
            r_mux_en <= w_do_out;
            r_done   <= w_do_halt;
            if (w_instr_rd) begin
                r_instr <= instr_data_i;
            end
            if (w_do_out) begin
                r_dev  <= instr_dev(r_instr);
                r_data <= w_op_data;
            end
            if (w_start) begin
                r_err   <= 1'b0;
                r_count <= 16'd0;
            end else begin
                if (w_illegal || w_timeout) begin
                    r_err <= 1'b1;
                end
                if (w_legal) begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    // Settle and idle-watchdog counters run only while in their states
    always_ff @(posedge fpga_clk_i) begin
        if (rst_i) begin
            r_settle  <= '0;
            r_timeout <= '0;
        end else begin
            r_settle  <= (r_state == StSettle && !stop_i) ? r_settle + SW'(1) : '0;
            r_timeout <= (r_state == StWaitIdle && !stop_i) ? r_timeout + TW'(1) : '0;
        end
    end

    assign instr_rd_o    = w_instr_rd;
    assign mux_en_o      = r_mux_en & ~stop_i;
    assign mux_device_o  = r_dev;
    assign mux_data_o    = r_data;
    assign busy_o        = (r_state != StIdle);
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign instr_count_o = r_count;

endmodule
